// File: rtl/skolem_check_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : skolem_check_ctrl
// Brief   : Exhaustive Skolem-function checker sweeping every input vector.
// Revision: 1.0  initial release
// =============================================================================
module skolem_check_ctrl #(
  parameter int N_IN   = 8,
  parameter int N_OUT  = 8,
  parameter int SETTLE = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              stop_on_fail,
  output logic [N_IN-1:0]   x_out,
  input  logic [N_OUT-1:0]  y_in,
  input  logic              spec_ok,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     fail_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_x,
  output logic [N_OUT-1:0]  first_fail_y
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [N_IN-1:0] c_x_last      = '1;
  localparam logic [3:0]      c_settle_last = 4'(SETTLE - 1);

  logic [1:0] r_state;
  logic [3:0] r_settle;
  logic       r_stop;

  assign busy = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
  assign done = (r_state == S_DONE);
  assign pass = done && (fail_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_settle         <= '0;
      r_stop           <= 1'b0;
      x_out            <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_x     <= '0;
      first_fail_y     <= '0;
    end else if (abort) begin
      // Results of the cancelled run stay visible for inspection.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state          <= S_DRIVE;
            x_out            <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            r_settle         <= '0;
            r_stop           <= stop_on_fail;
          end
        end
        S_DRIVE: begin
          if (r_settle == c_settle_last) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_settle <= '0;
          if (!spec_ok) begin
            fail_count <= fail_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_x     <= x_out;
              first_fail_y     <= y_in;
            end
          end
          // Stopping at the all-ones vector keeps x_out from wrapping.
          if ((x_out == c_x_last) || (r_stop && !spec_ok)) begin
            r_state <= S_DONE;
          end else begin
            x_out   <= x_out + 1'b1;
            r_state <= S_DRIVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_skolem_check_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_skolem_check_ctrl
// Brief   : Scoreboard bench for skolem_check_ctrl (SETTLE=1 and SETTLE=3).
// Revision: 1.0  initial release
// =============================================================================
module tb_skolem_check_ctrl;

  typedef struct {
    int         len;
    logic [8:0] fc;
    logic       pass;
    logic       ffv;
    logic [7:0] ffx;
    logic [7:0] ffy;
    logic [7:0] x;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, stop_on_fail = 1'b0, start3 = 1'b0;
  logic fault_mode = 1'b0;

  logic [7:0] x_out, y_in, ffx, ffy;
  logic       spec_ok, busy, done, pass, ffv;
  logic [8:0] fc;

  logic [7:0] x3, y3, ffx3, ffy3;
  logic       busy3, done3, pass3, ffv3;
  logic [8:0] fc3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  exp_t q[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath emulation: formula fails only at 0x2A and 0xC3 in fault mode.
  assign y_in    = x_out ^ 8'hFF;
  assign spec_ok = fault_mode ? !((x_out == 8'h2A) || (x_out == 8'hC3)) : 1'b1;
  assign y3      = x3 ^ 8'hFF;

  skolem_check_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_fail(stop_on_fail),
    .x_out(x_out), .y_in(y_in), .spec_ok(spec_ok), .busy(busy), .done(done),
    .pass(pass), .fail_count(fc), .first_fail_valid(ffv),
    .first_fail_x(ffx), .first_fail_y(ffy)
  );

  skolem_check_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .stop_on_fail(1'b0),
    .x_out(x3), .y_in(y3), .spec_ok(1'b1), .busy(busy3), .done(done3),
    .pass(pass3), .fail_count(fc3), .first_fail_valid(ffv3),
    .first_fail_x(ffx3), .first_fail_y(ffy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- result monitors ----------------
  logic done_q = 1'b0, done3_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("run_len", cyc - start_cyc, e.len);
        chk("fail_count", {23'd0, fc}, {23'd0, e.fc});
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("ff_valid", {31'd0, ffv}, {31'd0, e.ffv});
        chk("x_final", {24'd0, x_out}, {24'd0, e.x});
        if (e.ffv) begin
          chk("ff_x", {24'd0, ffx}, {24'd0, e.ffx});
          chk("ff_y", {24'd0, ffy}, {24'd0, e.ffy});
        end
      end
    end
    done_q = done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done3 && !done3_q) begin
      if (q3.size() == 0) chk("unexpected_done3", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("run_len3", cyc - start_cyc, e.len);
        chk("fail_count3", {23'd0, fc3}, {23'd0, e.fc});
        chk("pass3", {31'd0, pass3}, {31'd0, e.pass});
        chk("x_final3", {24'd0, x3}, {24'd0, e.x});
      end
    end
    done3_q = done3;
  end

  // ---------------- sweep-order monitors ----------------
  logic [7:0] prev_x = '0, prev_x3 = '0;
  int hold = 0, hold3 = 0;
  logic busy_q = 1'b0, busy3_q = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      if (!busy_q) begin
        chk("x_first", {24'd0, x_out}, 32'd0);
        hold = 1;
      end else if (x_out != prev_x) begin
        chk("x_step", {24'd0, x_out}, {24'd0, 8'(prev_x + 8'd1)});
        chk("x_hold", hold, 2);
        hold = 1;
      end else hold++;
      prev_x = x_out;
    end
    busy_q = busy;
  end

  always @(negedge clk) begin
    if (busy3) begin
      if (!busy3_q) begin
        chk("x3_first", {24'd0, x3}, 32'd0);
        hold3 = 1;
      end else if (x3 != prev_x3) begin
        chk("x3_step", {24'd0, x3}, {24'd0, 8'(prev_x3 + 8'd1)});
        chk("x3_hold", hold3, 4);
        hold3 = 1;
      end else hold3++;
      prev_x3 = x3;
    end
    busy3_q = busy3;
  end

  // ---------------- stimulus ----------------
  task automatic run_start(input logic sof, input logic fm, input logic with3);
    @(negedge clk);
    fault_mode   = fm;
    stop_on_fail = sof;
    start        = 1'b1;
    start3       = with3;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 3000; k++) begin
      if (q.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0 || q3.size() != 0) chk(name, 32'd1, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, {24'd0, x_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_fc"}, {23'd0, fc}, 32'd0);
    chk({tag, "_ffv"}, {31'd0, ffv}, 32'd0);
    chk({tag, "_ffx"}, {24'd0, ffx}, 32'd0);
    chk({tag, "_ffy"}, {24'd0, ffy}, 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean sweep on both instances in parallel.
    q.push_back('{len: 512, fc: 9'd0, pass: 1'b1, ffv: 1'b0, ffx: 8'h00, ffy: 8'h00, x: 8'hFF});
    q3.push_back('{len: 1024, fc: 9'd0, pass: 1'b1, ffv: 1'b0, ffx: 8'h00, ffy: 8'h00, x: 8'hFF});
    run_start(1'b0, 1'b0, 1'b1);
    wait_empty("timeout_clean");

    // Two failing vectors, full sweep.
    q.push_back('{len: 512, fc: 9'd2, pass: 1'b0, ffv: 1'b1, ffx: 8'h2A, ffy: 8'hD5, x: 8'hFF});
    run_start(1'b0, 1'b1, 1'b0);
    wait_empty("timeout_fail2");

    // Stop at first failure.
    q.push_back('{len: 86, fc: 9'd1, pass: 1'b0, ffv: 1'b1, ffx: 8'h2A, ffy: 8'hD5, x: 8'h2A});
    run_start(1'b1, 1'b1, 1'b0);
    wait_empty("timeout_stop");

    // Abort at cycle 100; first failure already captured and must survive.
    run_start(1'b0, 1'b1, 1'b0);
    repeat (98) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_fc", {23'd0, fc}, 32'd1);
    chk("abort_ffv", {31'd0, ffv}, 32'd1);
    chk("abort_ffx", {24'd0, ffx}, 32'h2A);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_wins_busy", {31'd0, busy}, 32'd0);
    q.push_back('{len: 512, fc: 9'd2, pass: 1'b0, ffv: 1'b1, ffx: 8'h2A, ffy: 8'hD5, x: 8'hFF});
    run_start(1'b0, 1'b1, 1'b0);
    wait_empty("timeout_restart");

    // Asynchronous reset between edges at cycle 300 of a run.
    run_start(1'b0, 1'b0, 1'b0);
    repeat (298) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_x", {24'd0, x_out}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("queue_empty", q.size() + q3.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
